// File: rtl/mem_copy.sv
// mem_copy: byte-wise copy / fill engine driving a single-port synchronous RAM.
// Copy moves one byte every three cycles (READ, CAPTURE, WRITE); fill writes
// one byte per cycle. Every output is a register that reflects the state the
// engine is currently in, so the RAM sees clean, glitch-free strobes.
module mem_copy #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  raw_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [7:0]            fill_value,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_wdata,
    output logic                  mem_write_enable,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH+1)'(0);

    // Control and datapath state
    state_t                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] src_q,    src_d;
    logic [ADDR_WIDTH-1:0] dst_q,    dst_d;
    logic [ADDR_WIDTH:0]   cnt_q,    cnt_d;
    logic                  mode_q,   mode_d;
    logic [7:0]            fill_q,   fill_d;
    logic [7:0]            data_q,   data_d;

    // Registered outputs
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [7:0]            wdata_q,  wdata_d;
    logic                  we_q,     we_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;

    assign mem_address      = addr_q;
    assign mem_wdata        = wdata_q;
    assign mem_write_enable = we_q;
    assign busy             = busy_q;
    assign done             = done_q;

    // State, operand and output registers with synchronous active-low reset
    always_ff @(posedge raw_clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            fill_q  <= 8'h00;
            data_q  <= 8'h00;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: operand latch in IDLE, byte sequencing, pointer advance
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    cnt_d  = length;
                    mode_d = mode;
                    fill_d = fill_value;
                    if (length == CNT_ZERO) begin
                        state_d = ST_FINISH;
                    end else if (mode) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // RAM output is valid now for the address presented in READ
                data_d  = mem_rdata;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Pointers wrap naturally at the top of the address space
                src_d = src_q + ADDR_ONE;
                dst_d = dst_q + ADDR_ONE;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_FINISH;
                end else if (mode_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs align with that state
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FINISH);
        case (state_d)
            ST_READ: begin
                addr_d = src_d;
            end
            ST_WRITE: begin
                addr_d = dst_d;
                // In copy mode data_d already holds the byte captured this cycle
                if (mode_d) begin
                    wdata_d = fill_d;
                end else begin
                    wdata_d = data_d;
                end
                we_d = 1'b1;
            end
            default: begin
                addr_d = addr_q;
            end
        endcase
    end

endmodule
